// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between the generator and its pixel consumer
interface vga_timing_gen_if #(
  parameter int X_W         = 11,
  parameter int Y_W         = 10,
  parameter int SCALE_SHIFT = 1,
  parameter int FRAME_W     = 8
);
  logic                         pixEn;
  logic                         hsync;
  logic                         vsync;
  logic                         displayOn;
  logic [X_W-SCALE_SHIFT-1:0]   screenX;
  logic [Y_W-SCALE_SHIFT-1:0]   screenY;
  logic                         lineStart;
  logic                         frameStart;
  logic [FRAME_W-1:0]           frameCount;

  // Generator side: consumes the pixel enable, drives all timing outputs.
  modport master (
    input  pixEn,
    output hsync, vsync, displayOn, screenX, screenY, lineStart, frameStart, frameCount
  );

  // Consumer side: supplies the pixel enable, observes the timing.
  modport slave (
    output pixEn,
    input  hsync, vsync, displayOn, screenX, screenY, lineStart, frameStart, frameCount
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator with scaled coordinates and frame counter
module vga_timing_gen #(
  parameter int H_DISPLAY   = 800,
  parameter int H_FRONT     = 40,
  parameter int H_SYNC      = 128,
  parameter int H_BACK      = 88,
  parameter int V_DISPLAY   = 600,
  parameter int V_FRONT     = 1,
  parameter int V_SYNC      = 4,
  parameter int V_BACK      = 23,
  parameter int H_POL       = 1,
  parameter int V_POL       = 1,
  parameter int SCALE_SHIFT = 1,
  parameter int X_W         = 11,
  parameter int Y_W         = 10,
  parameter int FRAME_W     = 8
) (
  input  logic           clk,
  input  logic           rst,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int SX_W    = X_W - SCALE_SHIFT;
  localparam int SY_W    = Y_W - SCALE_SHIFT;

  // Parameter sanity: counters must hold the full raster and the scaler is limited to /8.
  if (H_TOTAL > (1 << X_W)) begin : g_bad_x_w
    $error("vga_timing_gen: H_TOTAL does not fit in X_W bits");
  end
  if (V_TOTAL > (1 << Y_W)) begin : g_bad_y_w
    $error("vga_timing_gen: V_TOTAL does not fit in Y_W bits");
  end
  if (SCALE_SHIFT > 3 || SCALE_SHIFT < 0) begin : g_bad_shift
    $error("vga_timing_gen: SCALE_SHIFT must be 0..3");
  end

  // Comparisons are done one bit wider than the counters so a region boundary equal
  // to 2^X_W (or 2^Y_W) does not alias to zero.
  localparam logic [X_W:0]   H_DISP_C   = (X_W+1)'(H_DISPLAY);
  localparam logic [X_W:0]   HS_START_C = (X_W+1)'(H_DISPLAY + H_FRONT);
  localparam logic [X_W:0]   HS_STOP_C  = (X_W+1)'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [Y_W:0]   V_DISP_C   = (Y_W+1)'(V_DISPLAY);
  localparam logic [Y_W:0]   VS_START_C = (Y_W+1)'(V_DISPLAY + V_FRONT);
  localparam logic [Y_W:0]   VS_STOP_C  = (Y_W+1)'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [X_W-1:0] X_LAST     = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_LAST     = Y_W'(V_TOTAL - 1);
  localparam logic           HS_ON      = (H_POL != 0) ? 1'b1 : 1'b0;
  localparam logic           VS_ON      = (V_POL != 0) ? 1'b1 : 1'b0;

  // Raster position counters.
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [FRAME_W-1:0] fc_q, fc_d;

  // Registered outputs describing the position held one enabled clk earlier.
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               de_q, de_d;
  logic [SX_W-1:0]    sx_q, sx_d;
  logic [SY_W-1:0]    sy_q, sy_d;
  logic               ls_q, ls_d;
  logic               fs_q, fs_d;

  // Region decode of the current position.
  logic [X_W:0] x_ext;
  logic [Y_W:0] y_ext;
  logic         h_vis, v_vis, h_sync_act, v_sync_act;
  logic         x_at_end, y_at_end, at_origin_x, at_origin_y;

  assign x_ext       = {1'b0, x_q};
  assign y_ext       = {1'b0, y_q};
  assign h_vis       = (x_ext < H_DISP_C);
  assign v_vis       = (y_ext < V_DISP_C);
  assign h_sync_act  = (x_ext >= HS_START_C) && (x_ext < HS_STOP_C);
  assign v_sync_act  = (y_ext >= VS_START_C) && (y_ext < VS_STOP_C);
  assign x_at_end    = (x_q == X_LAST);
  assign y_at_end    = (y_q == Y_LAST);
  assign at_origin_x = (x_q == '0);
  assign at_origin_y = (y_q == '0);

  // Next-state: on an enabled clk sample the outputs from the current position and step the raster;
  // otherwise hold everything except the strobes, which drop so they never exceed one clk.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    fc_d = fc_q;
    hs_d = hs_q;
    vs_d = vs_q;
    de_d = de_q;
    sx_d = sx_q;
    sy_d = sy_q;
    ls_d = 1'b0;
    fs_d = 1'b0;
    if (bus.pixEn) begin
      hs_d = h_sync_act ? HS_ON : ~HS_ON;
      vs_d = v_sync_act ? VS_ON : ~VS_ON;
      de_d = h_vis && v_vis;
      sx_d = x_q[X_W-1:SCALE_SHIFT];
      sy_d = y_q[Y_W-1:SCALE_SHIFT];
      ls_d = at_origin_x;
      fs_d = at_origin_x && at_origin_y;
      if (x_at_end) begin
        x_d = '0;
        if (y_at_end) begin
          y_d  = '0;
          fc_d = fc_q + FRAME_W'(1);
        end else begin
          y_d = y_q + Y_W'(1);
        end
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
  end

  // State and output registers; reset forces idle sync levels and the raster origin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q  <= '0;
      y_q  <= '0;
      fc_q <= '0;
      hs_q <= ~HS_ON;
      vs_q <= ~VS_ON;
      de_q <= 1'b0;
      sx_q <= '0;
      sy_q <= '0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      fc_q <= fc_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
    end
  end

  assign bus.hsync      = hs_q;
  assign bus.vsync      = vs_q;
  assign bus.displayOn  = de_q;
  assign bus.screenX    = sx_q;
  assign bus.screenY    = sy_q;
  assign bus.lineStart  = ls_q;
  assign bus.frameStart = fs_q;
  assign bus.frameCount = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen against an arithmetic raster model
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pen = 1'b0;

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint k = 0;
  bit     en_last = 1'b0;

  vga_timing_gen_if #(.X_W(5), .Y_W(5), .SCALE_SHIFT(1), .FRAME_W(2)) a_if ();
  vga_timing_gen_if #(.X_W(5), .Y_W(4), .SCALE_SHIFT(2), .FRAME_W(3)) b_if ();
  vga_timing_gen_if c_if ();

  assign a_if.pixEn = pen;
  assign b_if.pixEn = pen;
  assign c_if.pixEn = pen;

  vga_timing_gen #(
    .H_DISPLAY(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
    .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(3), .V_BACK(4),
    .H_POL(1), .V_POL(1), .SCALE_SHIFT(1), .X_W(5), .Y_W(5), .FRAME_W(2)
  ) dut_a (.clk(clk), .rst(rst), .bus(a_if.master));

  vga_timing_gen #(
    .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(6), .H_BACK(6),
    .V_DISPLAY(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .H_POL(0), .V_POL(0), .SCALE_SHIFT(2), .X_W(5), .Y_W(4), .FRAME_W(3)
  ) dut_b (.clk(clk), .rst(rst), .bus(b_if.master));

  vga_timing_gen dut_c (.clk(clk), .rst(rst), .bus(c_if.master));

  typedef struct {
    int x; int y; int hs; int vs; int de; int sx; int sy; int ls; int fs; int fc;
  } exp_t;

  // Position after kk enabled clks is pixel number kk-1 of an endless raster scan.
  function automatic exp_t model(longint kk, bit enl, int hd, int hf, int hsw, int hb,
                                 int vd, int vf, int vsw, int vb, int hp, int vp, int sh, int fw);
    exp_t   e;
    longint ht, vt, p;
    ht = hd + hf + hsw + hb;
    vt = vd + vf + vsw + vb;
    if (kk == 0) begin
      e.x = 0; e.y = 0; e.hs = 1 - hp; e.vs = 1 - vp; e.de = 0;
      e.sx = 0; e.sy = 0; e.ls = 0; e.fs = 0; e.fc = 0;
      return e;
    end
    p    = kk - 1;
    e.x  = int'(p % ht);
    e.y  = int'((p / ht) % vt);
    e.hs = (e.x >= hd + hf && e.x < hd + hf + hsw) ? hp : 1 - hp;
    e.vs = (e.y >= vd + vf && e.y < vd + vf + vsw) ? vp : 1 - vp;
    e.de = (e.x < hd && e.y < vd) ? 1 : 0;
    e.sx = e.x >> sh;
    e.sy = e.y >> sh;
    e.ls = (enl && e.x == 0) ? 1 : 0;
    e.fs = (e.ls == 1 && e.y == 0) ? 1 : 0;
    e.fc = int'((kk / (ht * vt)) % (longint'(1) << fw));
    return e;
  endfunction

  function automatic exp_t model_a();
    return model(k, en_last, 20, 3, 5, 4, 12, 2, 3, 4, 1, 1, 1, 2);
  endfunction

  function automatic exp_t model_b();
    return model(k, en_last, 16, 2, 6, 6, 10, 1, 2, 3, 0, 0, 2, 3);
  endfunction

  task automatic step(input bit en);
    pen = en;
    @(posedge clk);
    if (en) k++;
    en_last = en;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    k = 0;
    en_last = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pen = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    k = 0;
    en_last = 1'b0;
    #1;
    checks++;
    if ({c_if.hsync, c_if.vsync, c_if.displayOn, c_if.lineStart, c_if.frameStart} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_c_ctrl got %b exp 00000",
               {c_if.hsync, c_if.vsync, c_if.displayOn, c_if.lineStart, c_if.frameStart});
    end
    checks++;
    if (c_if.screenX !== 10'd0 || c_if.screenY !== 9'd0 || c_if.frameCount !== 8'd0) begin
      errors++;
      $display("FAIL reset_c_counts got sx=%0d sy=%0d fc=%0d exp 0 0 0",
               c_if.screenX, c_if.screenY, c_if.frameCount);
    end
    checks++;
    if ({b_if.hsync, b_if.vsync, b_if.displayOn} !== 3'b110) begin
      errors++;
      $display("FAIL reset_b_neg_pol got %b exp 110", {b_if.hsync, b_if.vsync, b_if.displayOn});
    end
    @(negedge clk);
    rst = 1'b0;
    step(1'b1);
    checks++;
    if ({c_if.displayOn, c_if.lineStart, c_if.frameStart} !== 3'b111) begin
      errors++;
      $display("FAIL first_clk_strobes got %b exp 111", {c_if.displayOn, c_if.lineStart, c_if.frameStart});
    end
    checks++;
    if (c_if.screenX !== 10'd0 || c_if.screenY !== 9'd0) begin
      errors++;
      $display("FAIL first_clk_coords got %0d,%0d exp 0,0", c_if.screenX, c_if.screenY);
    end
  endtask

  task automatic test_random_model();
    exp_t ea, eb;
    do_reset();
    for (int i = 0; i < 2400; i++) begin
      step($urandom_range(0, 3) != 0);
      ea = model_a();
      eb = model_b();
      checks++;
      if ({a_if.hsync, a_if.vsync, a_if.displayOn, a_if.lineStart, a_if.frameStart, a_if.frameCount} !==
          {ea.hs[0], ea.vs[0], ea.de[0], ea.ls[0], ea.fs[0], ea.fc[1:0]}) begin
        errors++;
        $display("FAIL rand_a_ctrl k=%0d got %b exp %b", k,
                 {a_if.hsync, a_if.vsync, a_if.displayOn, a_if.lineStart, a_if.frameStart, a_if.frameCount},
                 {ea.hs[0], ea.vs[0], ea.de[0], ea.ls[0], ea.fs[0], ea.fc[1:0]});
      end
      if (ea.de == 1) begin
        checks++;
        if ({a_if.screenX, a_if.screenY} !== {ea.sx[3:0], ea.sy[3:0]}) begin
          errors++;
          $display("FAIL rand_a_coord k=%0d got %0d,%0d exp %0d,%0d", k,
                   a_if.screenX, a_if.screenY, ea.sx, ea.sy);
        end
      end
      checks++;
      if ({b_if.hsync, b_if.vsync, b_if.displayOn, b_if.lineStart, b_if.frameStart, b_if.frameCount} !==
          {eb.hs[0], eb.vs[0], eb.de[0], eb.ls[0], eb.fs[0], eb.fc[2:0]}) begin
        errors++;
        $display("FAIL rand_b_ctrl k=%0d got %b exp %b", k,
                 {b_if.hsync, b_if.vsync, b_if.displayOn, b_if.lineStart, b_if.frameStart, b_if.frameCount},
                 {eb.hs[0], eb.vs[0], eb.de[0], eb.ls[0], eb.fs[0], eb.fc[2:0]});
      end
      if (eb.de == 1) begin
        checks++;
        if ({b_if.screenX, b_if.screenY} !== {eb.sx[2:0], eb.sy[1:0]}) begin
          errors++;
          $display("FAIL rand_b_coord k=%0d got %0d,%0d exp %0d,%0d", k,
                   b_if.screenX, b_if.screenY, eb.sx, eb.sy);
        end
      end
    end
  endtask

  task automatic test_frame_wrap();
    int seen[$];
    int n;
    do_reset();
    n = 0;
    while (seen.size() < 5 && n < 5 * 672 + 100) begin
      step(1'b1);
      n++;
      if (a_if.frameStart === 1'b1) seen.push_back(int'(a_if.frameCount));
    end
    checks++;
    if (seen.size() != 5) begin
      errors++;
      $display("FAIL frame_wrap_count got %0d frameStarts exp 5", seen.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (seen[i] != i % 4) begin
          errors++;
          $display("FAIL frame_wrap_value idx=%0d got %0d exp %0d", i, seen[i], i % 4);
        end
      end
    end
  endtask

  task automatic test_default_line();
    int n, hs_cnt, de_cnt, first_hs, last_sx;
    bit found;
    do_reset();
    step(1'b1);
    n = 0; hs_cnt = 0; de_cnt = 0; first_hs = -1; last_sx = -1; found = 1'b0;
    while (!found && n < 1200) begin
      if (c_if.hsync === 1'b1) begin
        hs_cnt++;
        if (first_hs < 0) first_hs = n;
      end
      if (c_if.displayOn === 1'b1) begin
        de_cnt++;
        last_sx = int'(c_if.screenX);
      end
      step(1'b1);
      n++;
      if (c_if.lineStart === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || n != 1056) begin
      errors++;
      $display("FAIL line_period got %0d found=%0d exp 1056", n, found);
    end
    checks++;
    if (hs_cnt != 128 || first_hs != 840) begin
      errors++;
      $display("FAIL hsync_window got width=%0d start=%0d exp 128 840", hs_cnt, first_hs);
    end
    checks++;
    if (de_cnt != 800) begin
      errors++;
      $display("FAIL display_width got %0d exp 800", de_cnt);
    end
    checks++;
    if (last_sx != 399) begin
      errors++;
      $display("FAIL screenx_last got %0d exp 399", last_sx);
    end
  endtask

  task automatic test_pixen_alternate();
    int n, hold_err, wide_err;
    bit found, en;
    logic p_hs, p_vs, p_de, p_ls;
    logic [9:0] p_sx;
    logic [8:0] p_sy;
    logic [7:0] p_fc;
    do_reset();
    step(1'b1);
    n = 0; hold_err = 0; wide_err = 0; found = 1'b0;
    while (!found && n < 2300) begin
      p_hs = c_if.hsync; p_vs = c_if.vsync; p_de = c_if.displayOn; p_ls = c_if.lineStart;
      p_sx = c_if.screenX; p_sy = c_if.screenY; p_fc = c_if.frameCount;
      en = (n % 2 == 1);
      step(en);
      n++;
      if (!en && {c_if.hsync, c_if.vsync, c_if.displayOn, c_if.screenX, c_if.screenY, c_if.frameCount} !==
                 {p_hs, p_vs, p_de, p_sx, p_sy, p_fc})
        hold_err++;
      if ((c_if.lineStart === 1'b1 && p_ls === 1'b1) || (!en && c_if.frameStart !== 1'b0))
        wide_err++;
      if (c_if.lineStart === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || n != 2112) begin
      errors++;
      $display("FAIL alt_line_period got %0d found=%0d exp 2112", n, found);
    end
    checks++;
    if (hold_err != 0) begin
      errors++;
      $display("FAIL alt_hold got %0d changed cycles exp 0", hold_err);
    end
    checks++;
    if (wide_err != 0) begin
      errors++;
      $display("FAIL alt_strobe_width got %0d wide strobes exp 0", wide_err);
    end
  endtask

  task automatic test_mid_reset();
    int  n;
    bit  found;
    do_reset();
    repeat (501) step(1'b1);
    checks++;
    if (c_if.displayOn !== 1'b1 || c_if.screenX !== 10'd250) begin
      errors++;
      $display("FAIL mid_pos got de=%0d sx=%0d exp 1 250", c_if.displayOn, c_if.screenX);
    end
    #2;
    rst = 1'b1;
    k = 0;
    en_last = 1'b0;
    #1;
    checks++;
    if ({c_if.hsync, c_if.vsync, c_if.displayOn, c_if.lineStart, c_if.frameStart} !== 5'b00000 ||
        c_if.screenX !== 10'd0 || c_if.screenY !== 9'd0 || c_if.frameCount !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %b sx=%0d sy=%0d fc=%0d exp 00000 0 0 0",
               {c_if.hsync, c_if.vsync, c_if.displayOn, c_if.lineStart, c_if.frameStart},
               c_if.screenX, c_if.screenY, c_if.frameCount);
    end
    @(negedge clk);
    rst = 1'b0;
    step(1'b1);
    checks++;
    if (c_if.frameStart !== 1'b1 || c_if.screenX !== 10'd0) begin
      errors++;
      $display("FAIL mid_restart got fs=%0d sx=%0d exp 1 0", c_if.frameStart, c_if.screenX);
    end
    n = 0;
    found = 1'b0;
    while (!found && n < 1200) begin
      step(1'b1);
      n++;
      if (c_if.lineStart === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || n != 1056) begin
      errors++;
      $display("FAIL mid_line_period got %0d found=%0d exp 1056", n, found);
    end
  endtask

  initial begin
    test_reset();
    test_random_model();
    test_frame_wrap();
    test_default_line();
    test_pixen_alternate();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
